// File: rtl/roleda_pattern_gen.sv
// Stimulus source for the 5-input roleda detector: presents codewords on A..E
// together with the detector's expected F, under a valid/ready handshake.
module roleda_pattern_gen #(
   parameter int GAP_CYCLES = 0,
   parameter int PASSES     = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic mode,
   input  logic ready,
   output logic A,
   output logic B,
   output logic C,
   output logic D,
   output logic E,
   output logic valid,
   output logic expect_F,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

   localparam logic [4:0] CODE_M0   = 5'd22;
   localparam logic [4:0] CODE_M1   = 5'd26;
   localparam logic [3:0] GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

   state_t      state_reg, state_next;
   logic [4:0]  code_reg, code_next;
   logic        mode_reg, mode_next;
   logic [3:0]  gap_cnt_reg, gap_cnt_next;
   logic [7:0]  pass_cnt_reg, pass_cnt_next;
   logic        valid_reg, valid_next;
   logic        expect_reg, expect_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        seq_end;
   logic        run_end;
   logic [4:0]  succ_code;

   function automatic logic is_accept(input logic [4:0] c);
      return (c == CODE_M0) || (c == CODE_M1);
   endfunction

   // Successor in the latched sequence; both sequences wrap at their end.
   always_comb begin
      succ_code = code_reg + 5'd1;
      if (mode_reg)
         succ_code = (code_reg == CODE_M0) ? CODE_M1 : CODE_M0;
   end

   assign seq_end = mode_reg ? (code_reg == CODE_M1) : (code_reg == 5'd31);
   assign run_end = seq_end && (pass_cnt_reg == PASS_LAST);

   always_comb begin
      state_next    = state_reg;
      code_next     = code_reg;
      mode_next     = mode_reg;
      gap_cnt_next  = gap_cnt_reg;
      pass_cnt_next = pass_cnt_reg;
      valid_next    = valid_reg;
      expect_next   = expect_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               mode_next     = mode;
               code_next     = mode ? CODE_M0 : 5'd0;
               expect_next   = mode;
               valid_next    = 1'b1;
               busy_next     = 1'b1;
               gap_cnt_next  = 4'd0;
               pass_cnt_next = 8'd0;
               state_next    = EMIT;
            end
         end
         EMIT: begin
            if (ready) begin
               if (run_end) begin
                  valid_next    = 1'b0;
                  done_next     = 1'b1;
                  pass_cnt_next = 8'd0;
                  state_next    = DONE;
               end else begin
                  pass_cnt_next = pass_cnt_reg + {7'd0, seq_end};
                  if (GAP_CYCLES > 0) begin
                     // Code is held during the gap; it advances on leaving GAP.
                     valid_next   = 1'b0;
                     gap_cnt_next = 4'd0;
                     state_next   = GAP;
                  end else begin
                     code_next   = succ_code;
                     expect_next = is_accept(succ_code);
                  end
               end
            end
         end
         GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               gap_cnt_next = 4'd0;
               code_next    = succ_code;
               expect_next  = is_accept(succ_code);
               valid_next   = 1'b1;
               state_next   = EMIT;
            end else begin
               gap_cnt_next = gap_cnt_reg + 4'd1;
            end
         end
         DONE: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         code_reg     <= 5'd0;
         mode_reg     <= 1'b0;
         gap_cnt_reg  <= 4'd0;
         pass_cnt_reg <= 8'd0;
         valid_reg    <= 1'b0;
         expect_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         code_reg     <= code_next;
         mode_reg     <= mode_next;
         gap_cnt_reg  <= gap_cnt_next;
         pass_cnt_reg <= pass_cnt_next;
         valid_reg    <= valid_next;
         expect_reg   <= expect_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   assign A        = code_reg[4];
   assign B        = code_reg[3];
   assign C        = code_reg[2];
   assign D        = code_reg[1];
   assign E        = code_reg[0];
   assign valid    = valid_reg;
   assign expect_F = expect_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_roleda_pattern_gen.sv
// Scoreboard bench: stimulus queues expected codes, a monitor pops them on each
// accepted handshake; two instances cover the gapless and gapped configurations.
module tb_roleda_pattern_gen;

   typedef struct {
      logic [4:0] code;
      logic       f;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_a, start_a, mode_a, ready_a;
   logic a_A, a_B, a_C, a_D, a_E, valid_a, f_a, busy_a, done_a;
   logic rst_n_b, start_b, mode_b, ready_b;
   logic b_A, b_B, b_C, b_D, b_E, valid_b, f_b, busy_b, done_b;
   logic [4:0] code_a, code_b;

   assign code_a = {a_A, a_B, a_C, a_D, a_E};
   assign code_b = {b_A, b_B, b_C, b_D, b_E};

   roleda_pattern_gen #(.GAP_CYCLES(0), .PASSES(1)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .start(start_a), .mode(mode_a), .ready(ready_a),
      .A(a_A), .B(a_B), .C(a_C), .D(a_D), .E(a_E),
      .valid(valid_a), .expect_F(f_a), .busy(busy_a), .done(done_a)
   );

   roleda_pattern_gen #(.GAP_CYCLES(3), .PASSES(2)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .start(start_b), .mode(mode_b), .ready(ready_b),
      .A(b_A), .B(b_B), .C(b_C), .D(b_D), .E(b_E),
      .valid(valid_b), .expect_F(f_b), .busy(busy_b), .done(done_b)
   );

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt_a = 0;
   int   done_cnt_b = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Monitor: one line per accepted code.
   always @(negedge clk) begin
      if (rst_n_a && valid_a && ready_a) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_unexpected_code: got %0d, expected none", code_a);
         end else begin
            e_a = q_a.pop_front();
            check("a_code", 32'(code_a), 32'(e_a.code));
            check("a_expect_F", 32'(f_a), 32'(e_a.f));
         end
      end
      if (rst_n_b && valid_b && ready_b) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_unexpected_code: got %0d, expected none", code_b);
         end else begin
            e_b = q_b.pop_front();
            check("b_code", 32'(code_b), 32'(e_b.code));
            check("b_expect_F", 32'(f_b), 32'(e_b.f));
         end
      end
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sweep_a(input int last);
      for (int i = 0; i <= last; i++)
         q_a.push_back('{code: 5'(i), f: (i == 22 || i == 26)});
   endtask

   task automatic start_run_a(input logic m);
      start_a = 1'b1;
      mode_a  = m;
      step();
      start_a = 1'b0;
   endtask

   task automatic wait_done(input bit sel, input int budget, output int cyc);
      bit seen;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         seen = sel ? done_b : done_a;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int d0;
      rst_n_a = 1'b0; start_a = 1'b0; mode_a = 1'b0; ready_a = 1'b0;
      rst_n_b = 1'b0; start_b = 1'b0; mode_b = 1'b0; ready_b = 1'b0;
      step();
      step();
      @(negedge clk);
      check("rst_a_code", 32'(code_a), 0);
      check("rst_a_valid", 32'(valid_a), 0);
      check("rst_a_busy", 32'(busy_a), 0);
      check("rst_a_done", 32'(done_a), 0);
      check("rst_b_valid", 32'(valid_b), 0);
      check("rst_b_busy", 32'(busy_b), 0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;

      // Test 1: full sweep, back to back.
      ready_a = 1'b1;
      push_sweep_a(31);
      d0 = done_cnt_a;
      start_run_a(1'b0);
      @(negedge clk);
      check("t1_valid_lat1", 32'(valid_a), 1);
      check("t1_busy_lat1", 32'(busy_a), 1);
      wait_done(1'b0, 60, cyc);
      check("t1_done_latency", 32'(cyc), 32);
      check("t1_done_valid_low", 32'(valid_a), 0);
      @(negedge clk);
      check("t1_done_pulse_width", 32'(done_a), 0);
      check("t1_busy_after", 32'(busy_a), 0);
      check("t1_done_count", 32'(done_cnt_a - d0), 1);
      check("t1_queue_empty", 32'(q_a.size()), 0);

      // Test 3: ready pattern 1,0,0,1 stalls code 1 for three cycles.
      push_sweep_a(31);
      start_run_a(1'b0);
      step();
      ready_a = 1'b0;
      @(negedge clk);
      check("t3_hold1_code", 32'(code_a), 1);
      check("t3_hold1_valid", 32'(valid_a), 1);
      step();
      @(negedge clk);
      check("t3_hold2_code", 32'(code_a), 1);
      check("t3_hold2_valid", 32'(valid_a), 1);
      step();
      ready_a = 1'b1;
      @(negedge clk);
      check("t3_hold3_code", 32'(code_a), 1);
      wait_done(1'b0, 80, cyc);
      @(negedge clk);
      check("t3_queue_empty", 32'(q_a.size()), 0);

      // Test 6: start re-pulsed with mode=1 at code 5 is ignored.
      push_sweep_a(31);
      d0 = done_cnt_a;
      start_run_a(1'b0);
      for (int i = 0; i < 5; i++) step();
      start_a = 1'b1;
      mode_a  = 1'b1;
      step();
      start_a = 1'b0;
      wait_done(1'b0, 60, cyc);
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("t6_single_done", 32'(done_cnt_a - d0), 1);
      check("t6_busy_after", 32'(busy_a), 0);
      check("t6_queue_empty", 32'(q_a.size()), 0);

      // Test 5: reset while code 13 is presented, then match-only run.
      push_sweep_a(12);
      start_run_a(1'b0);
      for (int i = 0; i < 13; i++) step();
      rst_n_a = 1'b0;
      @(negedge clk);
      check("t5_pre_rst_code", 32'(code_a), 13);
      step();
      rst_n_a = 1'b1;
      @(negedge clk);
      check("t5_rst_code", 32'(code_a), 0);
      check("t5_rst_valid", 32'(valid_a), 0);
      check("t5_rst_expect_F", 32'(f_a), 0);
      check("t5_rst_busy", 32'(busy_a), 0);
      check("t5_rst_done", 32'(done_a), 0);
      check("t5_queue_empty", 32'(q_a.size()), 0);
      q_a.push_back('{code: 5'd22, f: 1'b1});
      q_a.push_back('{code: 5'd26, f: 1'b1});
      start_run_a(1'b1);
      @(negedge clk);
      check("t5_restart_code", 32'(code_a), 22);
      wait_done(1'b0, 20, cyc);
      @(negedge clk);
      check("t5_match_queue_empty", 32'(q_a.size()), 0);

      // Tests 2 and 4: match-only, two passes, three-cycle gaps.
      q_b.push_back('{code: 5'd22, f: 1'b1});
      q_b.push_back('{code: 5'd26, f: 1'b1});
      q_b.push_back('{code: 5'd22, f: 1'b1});
      q_b.push_back('{code: 5'd26, f: 1'b1});
      ready_b = 1'b1;
      d0 = done_cnt_b;
      start_b = 1'b1;
      mode_b  = 1'b1;
      step();
      start_b = 1'b0;
      step();
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         check("t4_gap_valid", 32'(valid_b), 0);
         check("t4_gap_code", 32'(code_b), 22);
         check("t4_gap_busy", 32'(busy_b), 1);
         step();
      end
      @(negedge clk);
      check("t4_after_gap_valid", 32'(valid_b), 1);
      check("t4_after_gap_code", 32'(code_b), 26);
      wait_done(1'b1, 40, cyc);
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("t2_single_done", 32'(done_cnt_b - d0), 1);
      check("t2_busy_after", 32'(busy_b), 0);
      check("t2_queue_empty", 32'(q_b.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/roleda_pattern_gen.md
Name: roleda_pattern_gen

Overview:
- Sequential stimulus source for the 5-input roleda detector. It drives codewords on A..E, one bit per detector input, with A as MSB.
- Each codeword comes with the detector's expected F and a valid/ready handshake. This lets a checker or downstream block compare the expected F against the detector's actual F cycle by cycle.
- Two modes:
  - sweep: all 32 codes, 0 to 31.
  - match-only: only the two accepted codewords, 5'b10110 then 5'b11010.

Parameters:
GAP_CYCLES, 0, idle cycles inserted after each accepted code before the next one is presented; legal range 0..15.
PASSES, 1, number of complete sequences emitted per start; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  begin a run; sampled only in IDLE.
mode  input  1  0 = sweep 0..31, 1 = match-only (22, 26); sampled with start.
ready  input  1  consumer accepts the current code when valid && ready.
A  output  1  code bit 4 (MSB).
B  output  1  code bit 3.
C  output  1  code bit 2.
D  output  1  code bit 1.
E  output  1  code bit 0 (LSB).
valid  output  1  A..E and expect_F are meaningful.
expect_F  output  1  1 iff {A,B,C,D,E} is 5'b10110 or 5'b11010.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the final code of the final pass is accepted.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clock edge), including mid-run:
  - state <= IDLE.
  - A..E, valid, expect_F, busy, done <= 0.
  - Code index, gap counter and pass counter <= 0.
- State machine: IDLE, EMIT, GAP, DONE.
- IDLE:
  - start=1 latches mode, loads the first code (0 in sweep, 22 in match-only), and goes to EMIT.
  - valid and busy rise the cycle after start is sampled (latency 1).
- EMIT:
  - valid=1. A..E and expect_F are held stable while ready=0; no code may change or drop while unaccepted.
  - On valid && ready, the next state depends on whether this was the last code of the last pass:
    - Last code of the last pass: go to DONE.
    - Otherwise, GAP_CYCLES>0: go to GAP.
    - Otherwise (GAP_CYCLES=0): stay in EMIT with the next code on the following cycle (back-to-back, one code per cycle).
- GAP:
  - valid=0. A..E hold their last values.
  - Counts GAP_CYCLES cycles, then returns to EMIT with the next code.
- DONE:
  - done=1 and valid=0 for exactly one cycle, then IDLE with busy=0.
- Code sequencing:
  - Sweep: 5-bit increment 0 to 31. After 31 the index wraps to 0 and the pass counter increments.
  - Match-only: 22, then 26. After 26 the sequence returns to 22 and the pass counter increments.
- A run ends when the pass counter reaches PASSES.
- expect_F is computed from the next code value and registered together with A..E, so it always matches the presented code in the same cycle.
- start asserted while busy is ignored; it does not restart the run.
- A mode change mid-run is ignored; the latched mode holds until IDLE.
- ready=1 outside EMIT has no effect.
- ready held low indefinitely stalls the run with valid=1 and the code frozen. No timeout.
- Accepted-code totals per run: PASSES*32 in sweep, PASSES*2 in match-only.

Test Plan:
1. Sweep, ready=1 throughout, GAP_CYCLES=0, PASSES=1, pulse start -> valid from cycle 1; codes 0..31 on consecutive cycles; expect_F=1 only at codes 22 and 26; done pulses one cycle after code 31; busy low afterwards.
2. Match-only, PASSES=2, ready=1 -> accepted sequence is 22, 26, 22, 26; expect_F=1 on all four; exactly one done pulse.
3. Sweep, ready toggling 1,0,0,1 from the first code -> code 0 accepted; code 1 held stable with valid=1 for 3 cycles, then accepted; no code skipped or duplicated.
4. GAP_CYCLES=3, match-only -> after 22 is accepted, valid=0 for 3 cycles with A..E still showing 10110; then 26 is presented.
5. Reset asserted while code 13 is presented in sweep -> next cycle all outputs 0, state IDLE. A new start with mode=1 then begins at 22.
6. start re-pulsed with mode=1 at code 5 of a sweep -> ignored; sweep continues 6..31; no second done.
